// File: rtl/bp_read_control.sv
// bp_read_control: pulls 512-bit beats from the DDR read FIFO and scatters them
// into the BP buffer array. Each conf loads two lines into two adjacent MAC groups.
// Optional feature macro: BP_READ_STALL_CNT_EN adds the stall_cycles output, which
// counts RUN cycles spent waiting on an empty FIFO.
module bp_read_control #(
    parameter int X_MAC        = 4,
    parameter int X_PE         = 16,
    parameter int X_MESH       = 16,
    parameter int DDR_ADDR_LEN = 32,
    parameter int ADDR_LEN     = 16,
    parameter int DATA_LEN     = 32,
    parameter int SINGLE_LEN   = 24,
    parameter int BUFFER_NUM   = 64
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           conf,
    input  logic [SINGLE_LEN-1:0]          data_ddr_byte,
    input  logic [DDR_ADDR_LEN-1:0]        ddr_st_addr,
    input  logic [ADDR_LEN-1:0]            BP_st_addr,
    input  logic [1:0]                     BP_st_num,
    input  logic [SINGLE_LEN-1:0]          Line_width,
    output logic [DDR_ADDR_LEN-1:0]        ddr_st_addr_out,
    output logic [SINGLE_LEN-1:0]          ddr_len,
    output logic                           ddr_conf,
    input  logic                           ddr_read_empty,
    output logic                           ddr_read_req,
    input  logic [DATA_LEN*X_MESH-1:0]     ddr_read_data_in,
    output logic [ADDR_LEN*BUFFER_NUM-1:0] BP_addr_out,
    output logic [DATA_LEN*BUFFER_NUM-1:0] BP_data_out,
    output logic [BUFFER_NUM-1:0]          BP_we_out,
    output logic                           idle
`ifdef BP_READ_STALL_CNT_EN
    ,
    output logic [SINGLE_LEN-1:0]          stall_cycles
`endif
);

    // The group field is 2 bits wide and each beat fills one word per mesh column,
    // so the geometry is fixed; reject any other configuration at elaboration.
    if (X_MAC != 4) begin : g_bad_mac
        $error("bp_read_control: X_MAC must be 4");
    end
    if (X_MESH * DATA_LEN != 512) begin : g_bad_beat
        $error("bp_read_control: X_MESH*DATA_LEN must be 512");
    end
    if (BUFFER_NUM != X_MAC * X_MESH) begin : g_bad_buf
        $error("bp_read_control: BUFFER_NUM must equal X_MAC*X_MESH");
    end
    if (X_PE < 1) begin : g_bad_pe
        $error("bp_read_control: X_PE must be positive");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state;
    logic [SINGLE_LEN-1:0] width_q;
    logic [ADDR_LEN-1:0]   base_addr;
    logic [ADDR_LEN-1:0]   cur_addr;
    logic [1:0]            cur_group;
    logic                  line_sel;
    logic [SINGLE_LEN-1:0] in_line;
    logic                  tag_valid;
    logic [1:0]            tag_group;
    logic [ADDR_LEN-1:0]   tag_addr;
    logic                  accept;
    logic                  last_in_line;

    assign accept       = conf && idle;
    assign last_in_line = (in_line == width_q - SINGLE_LEN'(1));
    assign ddr_read_req = (state == RUN) && !ddr_read_empty;
    assign idle         = (state == IDLE) && !tag_valid && (BP_we_out == '0);

    // Job control: latch a conf, walk the two lines request by request, then drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            ddr_st_addr_out <= '0;
            ddr_len         <= '0;
            ddr_conf        <= 1'b0;
            width_q         <= '0;
            base_addr       <= '0;
            cur_addr        <= '0;
            cur_group       <= '0;
            line_sel        <= 1'b0;
            in_line         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        ddr_st_addr_out <= ddr_st_addr;
                        ddr_len         <= data_ddr_byte;
                        width_q         <= Line_width;
                        base_addr       <= BP_st_addr;
                        cur_addr        <= BP_st_addr;
                        cur_group       <= BP_st_num;
                        line_sel        <= 1'b0;
                        in_line         <= '0;
                        if (Line_width != '0) begin
                            state    <= RUN;
                            ddr_conf <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    ddr_conf <= 1'b0;
                    if (ddr_read_req) begin
                        if (last_in_line) begin
                            in_line <= '0;
                            if (!line_sel) begin
                                line_sel  <= 1'b1;
                                cur_group <= cur_group + 2'd1;
                                cur_addr  <= base_addr;
                            end else begin
                                state <= DRAIN;
                            end
                        end else begin
                            in_line  <= in_line + SINGLE_LEN'(1);
                            cur_addr <= cur_addr + ADDR_LEN'(1);
                        end
                    end
                end
                DRAIN: begin
                    // The last request's tag is consumed on this edge, so the final
                    // BP write is registered here and the job is done.
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // One-deep tag pipeline: remembers where the beat requested this cycle belongs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_valid <= 1'b0;
            tag_group <= '0;
            tag_addr  <= '0;
        end else begin
            tag_valid <= ddr_read_req;
            if (ddr_read_req) begin
                tag_group <= cur_group;
                tag_addr  <= cur_addr;
            end
        end
    end

    // Scatter word m of the returned beat into buffer tag_group + m*X_MAC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            BP_we_out   <= '0;
            BP_addr_out <= '0;
            BP_data_out <= '0;
        end else begin
            for (int b = 0; b < BUFFER_NUM; b++) begin
                BP_we_out[b] <= 1'b0;
                if (tag_valid && (2'(b % X_MAC) == tag_group)) begin
                    BP_we_out[b]                         <= 1'b1;
                    BP_addr_out[b*ADDR_LEN +: ADDR_LEN]  <= tag_addr;
                    BP_data_out[b*DATA_LEN +: DATA_LEN]  <=
                        ddr_read_data_in[(b / X_MAC)*DATA_LEN +: DATA_LEN];
                end
            end
        end
    end

`ifdef BP_READ_STALL_CNT_EN
    // Saturating count of RUN cycles lost to an empty FIFO, restarted by each conf.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (accept) begin
            stall_cycles <= '0;
        end else if (state == RUN && ddr_read_empty && stall_cycles != '1) begin
            stall_cycles <= stall_cycles + SINGLE_LEN'(1);
        end
    end
`endif

endmodule

// File: tb/tb_bp_read_control.sv
// tb_bp_read_control: randomized bench for bp_read_control with a transaction-level
// reference model (k-th request of a job -> group/address) and shadow buffer contents.
module tb_bp_read_control;

    localparam int X_MAC = 4;
    localparam int X_MESH = 16;
    localparam int ADDR_LEN = 16;
    localparam int DATA_LEN = 32;
    localparam int SINGLE_LEN = 24;
    localparam int BUFFER_NUM = 64;

    logic                           clk = 1'b0;
    logic                           rst_n = 1'b0;
    logic                           conf = 1'b0;
    logic [SINGLE_LEN-1:0]          data_ddr_byte = '0;
    logic [31:0]                    ddr_st_addr = '0;
    logic [ADDR_LEN-1:0]            BP_st_addr = '0;
    logic [1:0]                     BP_st_num = '0;
    logic [SINGLE_LEN-1:0]          Line_width = '0;
    logic [31:0]                    ddr_st_addr_out;
    logic [SINGLE_LEN-1:0]          ddr_len;
    logic                           ddr_conf;
    logic                           ddr_read_empty = 1'b1;
    logic                           ddr_read_req;
    logic [DATA_LEN*X_MESH-1:0]     ddr_read_data_in = '0;
    logic [ADDR_LEN*BUFFER_NUM-1:0] BP_addr_out;
    logic [DATA_LEN*BUFFER_NUM-1:0] BP_data_out;
    logic [BUFFER_NUM-1:0]          BP_we_out;
    logic                           idle;
`ifdef BP_READ_STALL_CNT_EN
    logic [SINGLE_LEN-1:0]          stall_cycles;
`endif

    bp_read_control dut (
        .clk(clk), .rst_n(rst_n), .conf(conf), .data_ddr_byte(data_ddr_byte),
        .ddr_st_addr(ddr_st_addr), .BP_st_addr(BP_st_addr), .BP_st_num(BP_st_num),
        .Line_width(Line_width), .ddr_st_addr_out(ddr_st_addr_out), .ddr_len(ddr_len),
        .ddr_conf(ddr_conf), .ddr_read_empty(ddr_read_empty), .ddr_read_req(ddr_read_req),
        .ddr_read_data_in(ddr_read_data_in), .BP_addr_out(BP_addr_out),
        .BP_data_out(BP_data_out), .BP_we_out(BP_we_out), .idle(idle)
`ifdef BP_READ_STALL_CNT_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [1:0]  grp;
        logic [15:0] addr;
        logic [511:0] data;
    } beat_t;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int empty_mode = 0;
    int n_writes = 0;

    logic        conf_pend = 1'b0;
    logic [1:0]  cfg_num;
    logic [15:0] cfg_st;
    int          cfg_w;
    logic [31:0] cfg_ddr_addr;
    logic [23:0] cfg_len;

    logic        job_run = 1'b0;
    logic [1:0]  job_grp;
    logic [15:0] job_st;
    int          job_w = 0;
    int          job_k = 0;
    int          conf_cyc = -10;
    int          last_req = -10;
    logic [31:0] exp_ddr_addr = '0;
    logic [23:0] exp_ddr_len = '0;
    int          exp_stall = 0;

    beat_t        exp_q[$];
    logic         data_pend = 1'b0;
    logic [511:0] data_next;
    logic [15:0]  sh_addr[BUFFER_NUM];
    logic [31:0]  sh_data[BUFFER_NUM];

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic checkFields();
        for (int b = 0; b < BUFFER_NUM; b++) begin
            checkOutput($sformatf("addr%0d", b), 64'(BP_addr_out[b*ADDR_LEN +: ADDR_LEN]), 64'(sh_addr[b]));
            checkOutput($sformatf("data%0d", b), 64'(BP_data_out[b*DATA_LEN +: DATA_LEN]), 64'(sh_data[b]));
        end
    endtask

    function automatic logic [511:0] randBeat();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // One clock: check registered outputs against the model, then drive the next inputs.
    task automatic stepCycle();
        logic [63:0] exp_we;
        logic        busy;
        logic        exp_req;
        beat_t       b;
        @(negedge clk);
        cyc++;
        exp_we = '0;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            b = exp_q.pop_front();
            n_writes++;
            for (int m = 0; m < X_MESH; m++) begin
                exp_we[int'(b.grp) + m*X_MAC] = 1'b1;
                sh_addr[int'(b.grp) + m*X_MAC] = b.addr;
                sh_data[int'(b.grp) + m*X_MAC] = b.data[m*32 +: 32];
            end
        end
        checkOutput("we", BP_we_out, exp_we);
        if (exp_we != '0 || BP_we_out != '0) checkFields();
        checkOutput("ddr_conf", 64'(ddr_conf), 64'(job_run && cyc == conf_cyc + 1));
        checkOutput("ddr_addr", 64'(ddr_st_addr_out), 64'(exp_ddr_addr));
        checkOutput("ddr_len", 64'(ddr_len), 64'(exp_ddr_len));
`ifdef BP_READ_STALL_CNT_EN
        checkOutput("stall", 64'(stall_cycles), 64'(exp_stall));
`endif
        busy = job_run && (job_k < 2*job_w || cyc <= last_req + 2);
        checkOutput("idle", 64'(idle), 64'(!busy));
        if (!busy) job_run = 1'b0;

        if (data_pend) begin
            ddr_read_data_in = data_next;
            data_pend = 1'b0;
        end
        case (empty_mode)
            0:       ddr_read_empty = 1'b0;
            1:       ddr_read_empty = cyc[0];
            default: ddr_read_empty = ($urandom_range(0, 2) == 0);
        endcase
        conf = 1'b0;
        if (conf_pend) begin
            conf = 1'b1;
            conf_pend = 1'b0;
            if (!busy) begin
                exp_ddr_addr = cfg_ddr_addr;
                exp_ddr_len = cfg_len;
                exp_stall = 0;
                if (cfg_w != 0) begin
                    job_run = 1'b1;
                    job_grp = cfg_num;
                    job_st = cfg_st;
                    job_w = cfg_w;
                    job_k = 0;
                    conf_cyc = cyc;
                    last_req = -10;
                end
            end
        end
        #1;
        exp_req = job_run && cyc > conf_cyc && job_k < 2*job_w && !ddr_read_empty;
        if (job_run && cyc > conf_cyc && job_k < 2*job_w && ddr_read_empty) exp_stall++;
        checkOutput("req", 64'(ddr_read_req), 64'(exp_req));
        if (exp_req) begin
            b.due = cyc + 2;
            b.grp = job_grp + ((job_k >= job_w) ? 2'd1 : 2'd0);
            b.addr = job_st + 16'(job_k % job_w);
            b.data = randBeat();
            exp_q.push_back(b);
            data_next = b.data;
            data_pend = 1'b1;
            job_k++;
            if (job_k == 2*job_w) last_req = cyc;
        end
    endtask

    task automatic applyStimulus(input logic [1:0] num, input logic [15:0] st, input int w, input int mode);
        cfg_num = num;
        cfg_st = st;
        cfg_w = w;
        cfg_ddr_addr = $urandom;
        cfg_len = 24'($urandom);
        BP_st_num = num;
        BP_st_addr = st;
        Line_width = 24'(w);
        ddr_st_addr = cfg_ddr_addr;
        data_ddr_byte = cfg_len;
        empty_mode = mode;
        conf_pend = 1'b1;
    endtask

    task automatic waitDone();
        int n = 0;
        stepCycle();
        while ((job_run || exp_q.size() != 0) && n < 400) begin
            stepCycle();
            n++;
        end
        checkOutput("job_done", 64'(job_run || exp_q.size() != 0), 64'(0));
    endtask

    task automatic applyReset();
        @(negedge clk);
        cyc++;
        rst_n = 1'b0;
        conf = 1'b0;
        ddr_read_empty = 1'b1;
        #1;
        exp_q.delete();
        job_run = 1'b0;
        data_pend = 1'b0;
        conf_pend = 1'b0;
        exp_ddr_addr = '0;
        exp_ddr_len = '0;
        exp_stall = 0;
        for (int b = 0; b < BUFFER_NUM; b++) begin
            sh_addr[b] = '0;
            sh_data[b] = '0;
        end
        checkOutput("rst_we", BP_we_out, 64'(0));
        checkOutput("rst_conf", 64'(ddr_conf), 64'(0));
        checkOutput("rst_req", 64'(ddr_read_req), 64'(0));
        checkOutput("rst_ddr_addr", 64'(ddr_st_addr_out), 64'(0));
        checkOutput("rst_len", 64'(ddr_len), 64'(0));
        checkOutput("rst_idle", 64'(idle), 64'(1));
`ifdef BP_READ_STALL_CNT_EN
        checkOutput("rst_stall", 64'(stall_cycles), 64'(0));
`endif
        checkFields();
        @(negedge clk);
        cyc++;
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        applyReset();
        repeat (2) stepCycle();

        $display("[TB] basic load");
        applyStimulus(2'd1, 16'h0010, 3, 0);
        waitDone();

        $display("[TB] group wrap");
        applyStimulus(2'd3, 16'h0123, 2, 0);
        waitDone();

        $display("[TB] bursty fifo");
        applyStimulus(2'd2, 16'h0040, 4, 1);
        waitDone();

        $display("[TB] zero width");
        applyStimulus(2'd0, 16'h0077, 0, 0);
        repeat (6) stepCycle();

        $display("[TB] conf while busy");
        applyStimulus(2'd0, 16'h0100, 5, 2);
        repeat (4) stepCycle();
        applyStimulus(2'd1, 16'h0200, 5, 2);
        waitDone();

        $display("[TB] reset mid-job");
        applyStimulus(2'd1, 16'h0030, 4, 0);
        n_writes = 0;
        n = 0;
        while (n_writes < 3 && n < 100) begin
            stepCycle();
            n++;
        end
        checkOutput("writes_before_reset", 64'(n_writes), 64'(3));
        applyReset();
        applyStimulus(2'd2, 16'h0050, 4, 0);
        waitDone();

        $display("[TB] random jobs");
        for (int j = 0; j < 20; j++) begin
            applyStimulus(2'($urandom), (j % 4 == 0) ? 16'hFFFE : 16'($urandom),
                          int'($urandom_range(1, 6)), 2);
            waitDone();
            repeat ($urandom_range(0, 2)) stepCycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
